// File: rtl/etapa_inmediato.sv
// Immediate-generation stage: resolves the immediate type of an RV32I
// instruction (explicit or opcode-decoded), extracts and extends the
// immediate at accept time and holds results in a 2-entry in-order FIFO.
module etapa_inmediato #(
    parameter int XLEN = 32,
    parameter int ZIMM = 1,
    parameter int AUTO = 1
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [2:0]      tipo,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] inmediato,
    output logic [2:0]      out_tipo,
    output logic            error
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("etapa_inmediato: XLEN must be 32 or 64");
    end

    localparam logic [2:0] T_I    = 3'b000;
    localparam logic [2:0] T_S    = 3'b001;
    localparam logic [2:0] T_B    = 3'b010;
    localparam logic [2:0] T_U    = 3'b011;
    localparam logic [2:0] T_J    = 3'b100;
    localparam logic [2:0] T_Z    = 3'b101;
    localparam logic [2:0] T_ERR  = 3'b110;
    localparam logic [2:0] T_AUTO = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      tipo;
        logic            err;
    } entry_t;

    // Maps the requested type (possibly "auto") to a concrete type or T_ERR.
    function automatic logic [2:0] resolve(input logic [31:0] w, input logic [2:0] t);
        logic [2:0] r;
        r = T_ERR;
        case (t)
            T_I, T_S, T_B, T_U, T_J: r = t;
            T_Z:    r = (ZIMM != 0) ? T_Z : T_ERR;
            T_AUTO: begin
                if (AUTO != 0) begin
                    case (w[6:0])
                        7'b0010011, 7'b0000011, 7'b1100111: r = T_I;
                        7'b1110011: r = (w[14] && (ZIMM != 0)) ? T_Z : T_I;
                        7'b0100011: r = T_S;
                        7'b1100011: r = T_B;
                        7'b0110111, 7'b0010111: r = T_U;
                        7'b1101111: r = T_J;
                        default:    r = T_ERR;
                    endcase
                end
            end
            default: r = T_ERR;
        endcase
        return r;
    endfunction

    // Every type is first built as a 32-bit value whose bit 31 already carries
    // the correct extension (zero for Z), so one signed cast widens to XLEN.
    function automatic entry_t extract(input logic [31:0] w, input logic [2:0] t);
        entry_t     e;
        logic [2:0] r;
        logic [31:0] raw;
        r   = resolve(w, t);
        raw = '0;
        case (r)
            T_I: raw = {{20{w[31]}}, w[31:20]};
            T_S: raw = {{20{w[31]}}, w[31:25], w[11:7]};
            T_B: raw = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            T_U: raw = {w[31:12], 12'h000};
            T_J: raw = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            T_Z: raw = {27'h0, w[19:15]};
            default: raw = '0;
        endcase
        e.imm  = XLEN'($signed(raw));
        e.tipo = r;
        e.err  = (r == T_ERR);
        return e;
    endfunction

    logic [1:0] count;
    entry_t     head;
    entry_t     tail;
    entry_t     new_entry;
    logic       push;
    logic       pop;
    logic       unused_bits;

    assign unused_bits = ^inst[13:12];

    assign new_entry = extract(inst, tipo);
    assign in_ready  = nreset && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign inmediato = head.imm;
    assign out_tipo  = head.tipo;
    assign error     = head.err;

    // Two-slot shift FIFO: head drives the outputs, tail only fills when the
    // head is occupied and not leaving this cycle.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
                head <= new_entry;
            end else if (pop && count == 2'd2) begin
                head <= tail;
            end

            if (push && count == 2'd1 && !pop) begin
                tail <= new_entry;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_etapa_inmediato.sv
// Bench for etapa_inmediato: directed spec vectors, back-pressure, reset
// with a full FIFO, and randomized traffic against a scoreboard queue.
module tb_etapa_inmediato;

    localparam int XLEN = 32;
    localparam int ZIMM = 1;
    localparam int AUTO = 1;

    logic            clk;
    logic            nreset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [2:0]      tipo;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] inmediato;
    logic [2:0]      out_tipo;
    logic            error;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  t;
        logic        e;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic        stall_prev = 1'b0;
    logic [63:0] prev_imm   = '0;
    logic [2:0]  prev_tipo  = '0;
    logic        prev_err   = 1'b0;

    etapa_inmediato #(.XLEN(XLEN), .ZIMM(ZIMM), .AUTO(AUTO)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .tipo      (tipo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inmediato (inmediato),
        .out_tipo  (out_tipo),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input int v);
        logic [11:0] x;
        x = v[11:0];
        return {x, 5'd1, 3'b000, 5'd2, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_s(input int v);
        logic [11:0] x;
        x = v[11:0];
        return {x[11:5], 5'd3, 5'd1, 3'b010, x[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int v);
        logic [12:0] b;
        b = v[12:0];
        return {b[12], b[10:5], 5'd3, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int v);
        logic [31:0] u;
        u = v;
        return {u[31:12], 5'd1, 7'b0110111};
    endfunction

    function automatic logic [31:0] enc_j(input int v);
        logic [20:0] j;
        j = v[20:0];
        return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
    endfunction

    // Reference model written from the ISA field layout.
    function automatic res_t model(input logic [31:0] w, input logic [2:0] t);
        res_t        r;
        logic [2:0]  rt;
        longint      v;
        logic [63:0] mask;
        rt = t;
        if (t == 3'b110) rt = 3'b110;
        else if (t == 3'b101 && ZIMM == 0) rt = 3'b110;
        else if (t == 3'b111) begin
            if (AUTO == 0) rt = 3'b110;
            else begin
                case (w[6:0])
                    7'b0010011, 7'b0000011, 7'b1100111: rt = 3'b000;
                    7'b1110011: rt = (w[14] && ZIMM != 0) ? 3'b101 : 3'b000;
                    7'b0100011: rt = 3'b001;
                    7'b1100011: rt = 3'b010;
                    7'b0110111, 7'b0010111: rt = 3'b011;
                    7'b1101111: rt = 3'b100;
                    default:    rt = 3'b110;
                endcase
            end
        end
        case (rt)
            3'b000:  v = longint'($signed(w[31:20]));
            3'b001:  v = longint'($signed({w[31:25], w[11:7]}));
            3'b010:  v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            3'b011:  v = longint'($signed({w[31:12], 12'h000}));
            3'b100:  v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            3'b101:  v = longint'(w[19:15]);
            default: v = 0;
        endcase
        mask  = (XLEN == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        r.imm = 64'(v) & mask;
        r.t   = rt;
        r.e   = (rt == 3'b110);
        return r;
    endfunction

    // Scoreboard and output-hold monitor, sampled mid-cycle.
    always @(negedge clk) begin
        res_t e;
        if (nreset && in_valid && in_ready) q.push_back(model(inst, tipo));
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_imm", 64'(inmediato), prev_imm);
            chk("hold_tipo", 64'(out_tipo), 64'(prev_tipo));
            chk("hold_err", 64'(error), 64'(prev_err));
        end
        if (nreset && out_valid && out_ready) begin
            chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_imm", 64'(inmediato), e.imm);
                chk("sb_tipo", 64'(out_tipo), 64'(e.t));
                chk("sb_err", 64'(error), 64'(e.e));
            end
        end
        stall_prev = nreset && out_valid && !out_ready;
        prev_imm   = 64'(inmediato);
        prev_tipo  = out_tipo;
        prev_err   = error;
    end

    task automatic send_chk(input string tag, input logic [31:0] w, input logic [2:0] t,
                            input logic [63:0] ei, input logic [2:0] et, input logic ee);
        in_valid = 1'b1;
        inst     = w;
        tipo     = t;
        step();
        in_valid = 1'b0;
        inst     = $urandom;
        tipo     = 3'($urandom_range(0, 7));
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_imm"}, 64'(inmediato), ei);
        chk({tag, "_tipo"}, 64'(out_tipo), 64'(et));
        chk({tag, "_err"}, 64'(error), 64'(ee));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [10];
        int         k;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000};

        // Reset held with in_valid high: nothing may be accepted.
        nreset    = 1'b0;
        in_valid  = 1'b1;
        inst      = enc_i(5);
        tipo      = 3'b000;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(inmediato), 64'd0);
        chk("rst_tipo", 64'(out_tipo), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        nreset   = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);

        // Back-to-back directed vectors: each one replaces the previous head.
        out_ready = 1'b1;
        send_chk("i_pos", enc_i(2000), 3'b000, 64'h0000_07D0, 3'b000, 1'b0);
        send_chk("i_neg", enc_i(-2000), 3'b000, 64'hFFFF_F830, 3'b000, 1'b0);
        send_chk("b_neg", enc_b(-3000), 3'b010, 64'hFFFF_F448, 3'b010, 1'b0);
        send_chk("j_pos", enc_j(1000000), 3'b100, 64'h000F_4240, 3'b100, 1'b0);
        send_chk("u_neg", enc_u(-409600), 3'b011, 64'hFFF9_C000, 3'b011, 1'b0);
        send_chk("s_neg", enc_s(-1), 3'b001, 64'hFFFF_FFFF, 3'b001, 1'b0);
        send_chk("auto_j", enc_j(1000000), 3'b111, 64'h000F_4240, 3'b100, 1'b0);
        send_chk("auto_z", {12'h000, 5'b10101, 3'b101, 5'd0, 7'b1110011}, 3'b111, 64'd21, 3'b101, 1'b0);
        send_chk("auto_csr_i", {12'h7FF, 5'd3, 3'b001, 5'd1, 7'b1110011}, 3'b111, 64'h0000_07FF, 3'b000, 1'b0);
        send_chk("auto_bad", {25'h1ABCDEF, 7'b0000000}, 3'b111, 64'd0, 3'b110, 1'b1);
        send_chk("rsv", enc_i(100), 3'b110, 64'd0, 3'b110, 1'b1);
        step();
        chk("dir_drained", 64'(out_valid), 64'd0);

        // Back-pressure: A, B fill the FIFO, C waits.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tipo      = 3'b000;
        inst      = enc_i(11);
        step();
        chk("bp_a_rdy", 64'(in_ready), 64'd1);
        chk("bp_a_imm", 64'(inmediato), 64'd11);
        inst = enc_i(22);
        step();
        chk("bp_full_rdy", 64'(in_ready), 64'd0);
        chk("bp_a_hold1", 64'(inmediato), 64'd11);
        inst = enc_i(33);
        step();
        chk("bp_c_held", 64'(in_ready), 64'd0);
        chk("bp_a_hold2", 64'(inmediato), 64'd11);
        step();
        chk("bp_a_hold3", 64'(inmediato), 64'd11);
        out_ready = 1'b1;
        step();
        chk("bp_b", 64'(inmediato), 64'd22);
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_c", 64'(inmediato), 64'd33);
        chk("bp_c_valid", 64'(out_valid), 64'd1);
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Reset with two stale entries pending.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst      = enc_i(44);
        step();
        inst = enc_i(55);
        step();
        in_valid = 1'b0;
        chk("rf_full", 64'(in_ready), 64'd0);
        nreset = 1'b0;
        step();
        q.delete();
        chk("rf_out_valid", 64'(out_valid), 64'd0);
        chk("rf_imm", 64'(inmediato), 64'd0);
        chk("rf_tipo", 64'(out_tipo), 64'd0);
        chk("rf_err", 64'(error), 64'd0);
        chk("rf_in_ready_low", 64'(in_ready), 64'd0);
        nreset = 1'b1;
        #1;
        chk("rf_in_ready_rel", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        step();
        chk("rf_no_stale", 64'(out_valid), 64'd0);

        // Randomized traffic checked by the scoreboard monitor.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 65);
            inst      = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 9);
                inst[6:0] = ops[k];
            end
            tipo = 3'($urandom_range(0, 7));
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid; i++) step();
        chk("drain_empty", 64'(out_valid), 64'd0);
        chk("sb_leftover", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
